// File: rtl/bsa_pkg.sv
// Shared state encoding and default widths for the bit-serial in-array adder sequencer.
package bsa_pkg;

  localparam int unsigned BsaCols  = 8;
  localparam int unsigned BsaRowAw = 8;
  localparam int unsigned BsaNbW   = 5;

  typedef enum logic [2:0] {
    StIdle,
    StAct,
    StWait,
    StWrite,
    StCarry,
    StDone
  } bsa_state_e;

endpackage

// File: rtl/bitline_adder_slice.sv
// One column of the in-array adder: recovers A^B from the sensed AND/NOR pair and
// forms sum and carry-out against the latched carry.
module bitline_adder_slice (
  input  logic i_bl,
  input  logic i_blb,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_x;

  // Neither AND nor NOR set means exactly one operand bit is 1.
  assign w_x    = ~(i_bl | i_blb);
  assign o_sum  = w_x ^ i_cin;
  assign o_cout = (w_x & i_cin) | i_bl;

endmodule

// File: rtl/bitserial_add_seq.sv
// Bit-serial, column-parallel add sequencer for the SRAM compute array.
// Define BSA_CARRY_ROW_EN to write the final carry vector to row row_d+nbits.
module bitserial_add_seq
  import bsa_pkg::*;
#(
  parameter int unsigned COLS   = BsaCols,
  parameter int unsigned ROW_AW = BsaRowAw,
  parameter int unsigned NB_W   = BsaNbW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ROW_AW-1:0] i_row_a,
  input  logic [ROW_AW-1:0] i_row_b,
  input  logic [ROW_AW-1:0] i_row_d,
  input  logic [NB_W-1:0]   i_nbits,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_act_en,
  output logic [ROW_AW-1:0] o_act_row_a,
  output logic [ROW_AW-1:0] o_act_row_b,
  input  logic              i_sense_valid,
  input  logic [COLS-1:0]   i_bl,
  input  logic [COLS-1:0]   i_blb,
  output logic              o_wr_en,
  output logic [ROW_AW-1:0] o_wr_row,
  output logic [COLS-1:0]   o_wr_data
);

`ifdef BSA_CARRY_ROW_EN
  localparam bit CarryEn = 1'b1;
`else
  localparam bit CarryEn = 1'b0;
`endif

  bsa_state_e        r_state;
  bsa_state_e        w_state_next;
  logic [ROW_AW-1:0] r_row_a;
  logic [ROW_AW-1:0] r_row_b;
  logic [ROW_AW-1:0] r_row_d;
  logic [NB_W-1:0]   r_nbits;
  logic [NB_W-1:0]   r_idx;
  logic [COLS-1:0]   r_carry;
  logic [COLS-1:0]   r_wr_data;
  logic [COLS-1:0]   w_sum;
  logic [COLS-1:0]   w_cout;
  logic [ROW_AW-1:0] w_idx_ext;
  logic              w_last;

  assign w_idx_ext = ROW_AW'(r_idx);
  assign w_last    = (r_idx + NB_W'(1)) == r_nbits;

  for (genvar g = 0; g < int'(COLS); g++) begin : g_slice
    bitline_adder_slice u_slice (
      .i_bl  (i_bl[g]),
      .i_blb (i_blb[g]),
      .i_cin (r_carry[g]),
      .o_sum (w_sum[g]),
      .o_cout(w_cout[g])
    );
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_act_en     = 1'b0;
    o_act_row_a  = '0;
    o_act_row_b  = '0;
    o_wr_en      = 1'b0;
    o_wr_row     = '0;
    o_wr_data    = r_wr_data;
    case (r_state)
      StIdle: begin
        if (i_start) w_state_next = (i_nbits == '0) ? StDone : StAct;
      end
      StAct: begin
        o_busy       = 1'b1;
        o_act_en     = 1'b1;
        o_act_row_a  = r_row_a + w_idx_ext;
        o_act_row_b  = r_row_b + w_idx_ext;
        w_state_next = StWait;
      end
      StWait: begin
        o_busy = 1'b1;
        if (i_sense_valid) w_state_next = StWrite;
      end
      StWrite: begin
        o_busy   = 1'b1;
        o_wr_en  = 1'b1;
        o_wr_row = r_row_d + w_idx_ext;
        if (w_last) w_state_next = CarryEn ? StCarry : StDone;
        else        w_state_next = StAct;
      end
      StCarry: begin
        // r_idx has already advanced to nbits, so this addresses row_d+nbits.
        o_busy       = 1'b1;
        o_wr_en      = 1'b1;
        o_wr_row     = r_row_d + w_idx_ext;
        o_wr_data    = r_carry;
        w_state_next = StDone;
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_row_a   <= '0;
      r_row_b   <= '0;
      r_row_d   <= '0;
      r_nbits   <= '0;
      r_idx     <= '0;
      r_carry   <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_row_a <= i_row_a;
            r_row_b <= i_row_b;
            r_row_d <= i_row_d;
            r_nbits <= i_nbits;
            r_idx   <= '0;
            r_carry <= '0;
          end
        end
        StWait: begin
          if (i_sense_valid) begin
            r_wr_data <= w_sum;
            r_carry   <= w_cout;
          end
        end
        StWrite: r_idx <= r_idx + NB_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_add_seq.sv
// Scoreboard bench: an array model answers activations, an arithmetic reference model
// predicts every activation, write and done cycle, and a monitor checks them as they occur.
module tb_bitserial_add_seq;

  localparam int unsigned COLS   = 8;
  localparam int unsigned ROW_AW = 8;
  localparam int unsigned NB_W   = 5;

`ifdef BSA_CARRY_ROW_EN
  localparam bit CarryEn = 1'b1;
`else
  localparam bit CarryEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ROW_AW-1:0] row_a = '0;
  logic [ROW_AW-1:0] row_b = '0;
  logic [ROW_AW-1:0] row_d = '0;
  logic [NB_W-1:0]   nbits = '0;
  logic              busy;
  logic              done;
  logic              act_en;
  logic [ROW_AW-1:0] act_row_a;
  logic [ROW_AW-1:0] act_row_b;
  logic              sense_valid = 1'b0;
  logic [COLS-1:0]   bl = '0;
  logic [COLS-1:0]   blb = '0;
  logic              wr_en;
  logic [ROW_AW-1:0] wr_row;
  logic [COLS-1:0]   wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit spur_en = 1'b0;
  bit junk_en = 1'b0;
  int resp_cnt = 0;
  logic [ROW_AW-1:0] resp_ra;
  logic [ROW_AW-1:0] resp_rb;

  logic [COLS-1:0] mem [256];
  logic [15:0]     exp_act [$];
  logic [15:0]     exp_wr [$];
  int              exp_done [$];

  bitserial_add_seq dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_row_a      (row_a),
    .i_row_b      (row_b),
    .i_row_d      (row_d),
    .i_nbits      (nbits),
    .o_busy       (busy),
    .o_done       (done),
    .o_act_en     (act_en),
    .o_act_row_a  (act_row_a),
    .o_act_row_b  (act_row_b),
    .i_sense_valid(sense_valid),
    .i_bl         (bl),
    .i_blb        (blb),
    .o_wr_en      (wr_en),
    .o_wr_row     (wr_row),
    .o_wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Array model: senses AND/NOR of the two activated rows after 'lat' cycles, stores writes.
  always @(negedge clk) begin
    sense_valid = 1'b0;
    bl          = '0;
    blb         = '0;
    if (rst) begin
      resp_cnt = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          sense_valid = 1'b1;
          bl          = mem[resp_ra] & mem[resp_rb];
          blb         = ~(mem[resp_ra] | mem[resp_rb]);
        end
      end else if (spur_en && !act_en && ($urandom_range(0, 1) == 1)) begin
        sense_valid = 1'b1;
        bl          = COLS'($urandom);
        blb         = COLS'($urandom);
      end
      if (act_en) begin
        resp_cnt = lat;
        resp_ra  = act_row_a;
        resp_rb  = act_row_b;
      end
      if (wr_en) mem[wr_row] = wr_data;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an activation, write or done.
  always @(negedge clk) begin
    logic [15:0] e;
    int          ed;
    if (!rst) begin
      if (act_en || wr_en) chk("act_wr_exclusive", 64'(act_en & wr_en), 64'd0);
      if (act_en) begin
        chk("act_expected", 64'(exp_act.size() > 0), 64'd1);
        if (exp_act.size() > 0) begin
          e = exp_act.pop_front();
          chk("act_rows", 64'({act_row_a, act_row_b}), 64'(e));
        end
        chk("busy_in_act", 64'(busy), 64'd1);
      end
      if (wr_en) begin
        chk("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("wr_row_data", 64'({wr_row, wr_data}), 64'(e));
        end
      end
      if (done) begin
        chk("done_expected", 64'(exp_done.size() > 0), 64'd1);
        if (exp_done.size() > 0) begin
          ed = exp_done.pop_front();
          chk("done_cycle", 64'(cyc), 64'(ed));
        end
        chk("busy_low_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Reference model: operands are column-wise integers read from the array rows.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                       input logic [4:0] n);
    longint unsigned s_col [COLS];
    logic [COLS-1:0] dat;
    int              total;
    for (int c = 0; c < int'(COLS); c++) begin
      longint unsigned av;
      longint unsigned bv;
      av = 0;
      bv = 0;
      for (int k = 0; k < int'(n); k++) begin
        av[k] = mem[8'(a + k)][c];
        bv[k] = mem[8'(b + k)][c];
      end
      s_col[c] = av + bv;
    end
    for (int k = 0; k < int'(n); k++) begin
      exp_act.push_back({8'(a + k), 8'(b + k)});
      for (int c = 0; c < int'(COLS); c++) dat[c] = s_col[c][k];
      exp_wr.push_back({8'(d + k), dat});
    end
    if (CarryEn && n != 0) begin
      for (int c = 0; c < int'(COLS); c++) dat[c] = s_col[c][n];
      exp_wr.push_back({8'(d + n), dat});
    end
    total = (n == 0) ? 1 : int'(n) * (2 + lat) + (CarryEn ? 1 : 0) + 1;
    exp_done.push_back(cyc + total);
    row_a = a;
    row_b = b;
    row_d = d;
    nbits = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      if (junk_en) begin
        start = 1'($urandom);
        row_a = 8'($urandom);
        row_b = 8'($urandom);
        row_d = 8'($urandom);
        nbits = 5'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("done_within_budget", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] a;
    int         acts;
    for (int r = 0; r < 256; r++) mem[r] = COLS'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_act_en", 64'(act_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_addr_data", 64'({act_row_a, act_row_b, wr_row, wr_data}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 5 + 3 in column 0: sum 8 -> bits 0,0,0,1, carry 0.
    for (int k = 0; k < 4; k++) begin
      mem[8'(8'h10 + k)][0] = 1'((5 >> k) & 1);
      mem[8'(8'h50 + k)][0] = 1'((3 >> k) & 1);
    end
    issue(8'h10, 8'h50, 8'h90, 5'd4);
    wait_done(100);
    chk("five_plus_three_bit0", 64'(mem[8'h90][0]), 64'd0);
    chk("five_plus_three_bit1", 64'(mem[8'h91][0]), 64'd0);
    chk("five_plus_three_bit2", 64'(mem[8'h92][0]), 64'd0);
    chk("five_plus_three_bit3", 64'(mem[8'h93][0]), 64'd1);

    // F + 1 in column 0: low four bits 0, carry row gets 1 only with the carry feature.
    for (int k = 0; k < 4; k++) begin
      mem[8'(8'h20 + k)][0] = 1'b1;
      mem[8'(8'h60 + k)][0] = 1'(k == 0);
    end
    mem[8'hA4] = '0;
    issue(8'h20, 8'h60, 8'hA0, 5'd4);
    wait_done(100);
    chk("f_plus_one_low", 64'({mem[8'hA3][0], mem[8'hA2][0], mem[8'hA1][0], mem[8'hA0][0]}),
        64'd0);
    chk("f_plus_one_carry_row", 64'(mem[8'hA4][0]), 64'(CarryEn));

    // Zero-width operation: done on the next cycle, no array traffic.
    issue(8'h30, 8'h70, 8'hB0, 5'd0);
    wait_done(10);

    // Row address wrap.
    issue(8'hFE, 8'h3E, 8'h7E, 5'd4);
    wait_done(100);

    // Slow sense, spurious sense_valid outside WAIT, start pulses while busy.
    lat     = 5;
    spur_en = 1'b1;
    junk_en = 1'b1;
    issue(8'h05, 8'h45, 8'h85, 5'd7);
    wait_done(200);
    junk_en = 1'b0;
    spur_en = 1'b0;

    // Randomised operations with disjoint operand/destination windows.
    for (int t = 0; t < 20; t++) begin
      lat     = int'($urandom_range(1, 4));
      spur_en = 1'($urandom);
      a       = 8'($urandom);
      issue(a, 8'(a + 8'd64), 8'(a + 8'd128), 5'($urandom_range(0, 12)));
      wait_done(300);
    end
    spur_en = 1'b0;

    // Abort in WAIT of bit 2, then a fresh operation.
    lat = 5;
    for (int k = 0; k < 6; k++) begin
      mem[8'(8'h08 + k)] = '1;
      mem[8'(8'h48 + k)] = '1;
    end
    issue(8'h08, 8'h48, 8'h88, 5'd6);
    acts = 0;
    for (int k = 0; k < 200 && acts < 3; k++) begin
      if (act_en) acts++;
      if (acts < 3) @(negedge clk);
    end
    chk("third_act_seen", 64'(acts), 64'd3);
    @(negedge clk);
    rst = 1'b1;
    exp_act.delete();
    exp_wr.delete();
    exp_done.delete();
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_strobes", 64'({act_en, wr_en}), 64'd0);
    chk("abort_addr_data", 64'({act_row_a, act_row_b, wr_row, wr_data}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    lat = 1;
    issue(8'h18, 8'h58, 8'h98, 5'd5);
    wait_done(100);

    repeat (4) @(negedge clk);
    chk("act_queue_drained", 64'(exp_act.size()), 64'd0);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
